tristate_bus_master: RTL and testbench

Sequencing master for the 8-bit bidirectional parallel bus that feeds sub-module inout ports such as io_bus0/io_bus1. It sits directly upstream of those ports: it converts a valid/ready command stream into timed drive/strobe/release phases on the pulled bus. It samples read data and returns it on a response handshake. The bus is externally terminated by weak pull-ups, so an undriven bus reads 8'hFF.

---
 rtl/tristate_bus_master_pkg.sv | 29 ++
 rtl/tristate_bus_master_if.sv | 28 ++
 rtl/tristate_bus_master_bus_phase_counter.sv | 30 +++
 rtl/tristate_bus_master.sv | 117 +++++++++++
 tb/tb_tristate_bus_master.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_master_pkg.sv
// Shared types and default timing for the tri-state bus master.
package tristate_bus_pkg;

  localparam int DATA_W             = 8;
  localparam int CNT_W              = 4;
  localparam int DEF_SETUP_CYCLES   = 1;
  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_HOLD_CYCLES    = 1;
  localparam int DEF_TURN_CYCLES    = 1;

  // state      | meaning
  // IDLE       | ready for a command, bus released
  // W_SETUP    | write data driven, strobe low
  // W_STROBE   | write data driven, strobe high
  // W_HOLD     | write data held after strobe falls
  // R_STROBE   | bus released, strobe high, sample on last cycle
  // TURN       | bus released before ownership can change
  // RESP       | completion presented, waiting for rsp_ready
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_STROBE = 3'd4,
    ST_TURN     = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

endpackage

// File: rtl/tristate_bus_master_if.sv
// Command/response handshake plus bus control observability signals.
// The data pads themselves stay a plain inout on the top level.
interface tristate_bus_master_if
  import tristate_bus_pkg::*;
#(
  parameter int DW = DATA_W
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_data;
  logic          io_strobe;
  logic          bus_oe;

  modport master (
    input  req_valid, req_write, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_data, io_strobe, bus_oe
  );

  modport slave (
    output req_valid, req_write, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_data, io_strobe, bus_oe
  );
endinterface

// File: rtl/tristate_bus_master_bus_phase_counter.sv
// Down-counter timing each bus phase; saturates at zero.
module bus_phase_counter
  import tristate_bus_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tristate_bus_master.sv
// Sequences valid/ready commands into drive/strobe/release phases on a
// pulled-up 8-bit bus and returns a completion on a response handshake.
module tristate_bus_master #(
  parameter int DATA_W        = tristate_bus_pkg::DATA_W,
  parameter int SETUP_CYCLES  = tristate_bus_pkg::DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = tristate_bus_pkg::DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = tristate_bus_pkg::DEF_HOLD_CYCLES,
  parameter int TURN_CYCLES   = tristate_bus_pkg::DEF_TURN_CYCLES,
  parameter int CNT_W         = tristate_bus_pkg::CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  tristate_bus_master_if.master   bus,
  inout  wire  [DATA_W-1:0]       io_bus
);
  import tristate_bus_pkg::*;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_write_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              bus_oe_q;
  logic              strobe_q;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_en;
  logic              cnt_zero;
  logic              accept;

  assign accept = bus.req_valid && req_ready_q;
  assign cnt_en = state_q inside {ST_W_SETUP, ST_W_STROBE, ST_W_HOLD,
                                  ST_R_STROBE, ST_TURN};

  bus_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_val),
    .enable     (cnt_en),
    .zero       (cnt_zero)
  );

  // Next state and counter reload on entry to each timed phase.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (bus.req_write) begin
            state_d      = ST_W_SETUP;
            cnt_load_val = SETUP_LD;
          end else begin
            state_d      = ST_R_STROBE;
            cnt_load_val = STROBE_LD;
          end
        end
      end
      ST_W_SETUP: if (cnt_zero) begin
        state_d = ST_W_STROBE; cnt_load = 1'b1; cnt_load_val = STROBE_LD;
      end
      ST_W_STROBE: if (cnt_zero) begin
        state_d = ST_W_HOLD; cnt_load = 1'b1; cnt_load_val = HOLD_LD;
      end
      ST_W_HOLD, ST_R_STROBE: if (cnt_zero) begin
        state_d = ST_TURN; cnt_load = 1'b1; cnt_load_val = TURN_LD;
      end
      ST_TURN: if (cnt_zero) state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      bus_oe_q    <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      bus_oe_q    <= state_d inside {ST_W_SETUP, ST_W_STROBE, ST_W_HOLD};
      strobe_q    <= state_d inside {ST_W_STROBE, ST_R_STROBE};
      if (state_q == ST_IDLE && accept) begin
        data_q      <= bus.req_data;
        rsp_write_q <= bus.req_write;
      end
      if (state_q == ST_R_STROBE && cnt_zero) rsp_data_q <= io_bus;
      if (state_q == ST_W_HOLD && cnt_zero)   rsp_data_q <= data_q;
    end
  end

  assign io_bus        = bus_oe_q ? data_q : {DATA_W{1'bz}};
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.io_strobe = strobe_q;
  assign bus.bus_oe    = bus_oe_q;

endmodule

// File: tb/tb_tristate_bus_master.sv
// Directed bench: default-timing DUT plus a slow-timing DUT for back-to-back.
module tb_tristate_bus_master;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  wire [7:0] io_bus1;
  wire [7:0] io_bus2;
  logic      drive_mode;

  tristate_bus_master_if #(.DW(8)) if1 ();
  tristate_bus_master_if #(.DW(8)) if2 ();

  pullup (io_bus1);
  pullup (io_bus2);

  assign io_bus1 = (drive_mode && if1.io_strobe) ? 8'h3C : 8'hzz;

  tristate_bus_master dut1 (
    .clock  (clock),
    .reset  (reset),
    .bus    (if1),
    .io_bus (io_bus1)
  );

  tristate_bus_master #(
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (3),
    .HOLD_CYCLES   (2),
    .TURN_CYCLES   (2)
  ) dut2 (
    .clock  (clock),
    .reset  (reset),
    .bus    (if2),
    .io_bus (io_bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task test_reset();
    reset = 1'b1;
    #1;
    checks++; if (if1.bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", if1.bus_oe); end
    checks++; if (if1.io_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", if1.io_strobe); end
    checks++; if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", if1.rsp_valid); end
    checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", if1.req_ready); end
    checks++; if (if1.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", if1.rsp_data); end
    checks++; if (if1.rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_write: got %b want 0", if1.rsp_write); end
    checks++; if (io_bus1 !== 8'hFF) begin errors++; $display("FAIL reset_bus_released: got %h want FF", io_bus1); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_exit_ready: got %b want 1", if1.req_ready); end
    checks++; if (if2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_exit_ready2: got %b want 1", if2.req_ready); end
  endtask

  task test_write();
    logic       e_oe, e_stb;
    logic [7:0] e_bus;
    @(negedge clock);
    if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_data = 8'hA5; if1.rsp_ready = 1'b1;
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      e_oe  = (c >= 1 && c <= 4);
      e_bus = e_oe ? 8'hA5 : 8'hFF;
      e_stb = (c == 2 || c == 3);
      checks++; if (if1.bus_oe !== e_oe) begin errors++; $display("FAIL wr_oe c%0d: got %b want %b", c, if1.bus_oe, e_oe); end
      checks++; if (io_bus1 !== e_bus) begin errors++; $display("FAIL wr_bus c%0d: got %h want %h", c, io_bus1, e_bus); end
      checks++; if (if1.io_strobe !== e_stb) begin errors++; $display("FAIL wr_strobe c%0d: got %b want %b", c, if1.io_strobe, e_stb); end
      checks++; if (if1.rsp_valid !== (c == 6)) begin errors++; $display("FAIL wr_rsp_valid c%0d: got %b want %b", c, if1.rsp_valid, (c == 6)); end
      checks++; if (if1.req_ready !== (c == 7)) begin errors++; $display("FAIL wr_req_ready c%0d: got %b want %b", c, if1.req_ready, (c == 7)); end
      if (c == 6) begin
        checks++; if (if1.rsp_write !== 1'b1) begin errors++; $display("FAIL wr_rsp_write: got %b want 1", if1.rsp_write); end
        checks++; if (if1.rsp_data !== 8'hA5) begin errors++; $display("FAIL wr_rsp_data: got %h want A5", if1.rsp_data); end
      end
    end
  endtask

  task test_read(input logic drive, input logic [7:0] exp_data);
    @(negedge clock);
    drive_mode = drive;
    if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.req_data = 8'h99; if1.rsp_ready = 1'b1;
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      checks++; if (if1.bus_oe !== 1'b0) begin errors++; $display("FAIL rd_oe c%0d: got %b want 0", c, if1.bus_oe); end
      checks++; if (if1.io_strobe !== (c <= 2)) begin errors++; $display("FAIL rd_strobe c%0d: got %b want %b", c, if1.io_strobe, (c <= 2)); end
      checks++; if (if1.rsp_valid !== (c == 4)) begin errors++; $display("FAIL rd_rsp_valid c%0d: got %b want %b", c, if1.rsp_valid, (c == 4)); end
      checks++; if (if1.req_ready !== (c == 5)) begin errors++; $display("FAIL rd_req_ready c%0d: got %b want %b", c, if1.req_ready, (c == 5)); end
      if (c == 4) begin
        checks++; if (if1.rsp_data !== exp_data) begin errors++; $display("FAIL rd_rsp_data: got %h want %h", if1.rsp_data, exp_data); end
        checks++; if (if1.rsp_write !== 1'b0) begin errors++; $display("FAIL rd_rsp_write: got %b want 0", if1.rsp_write); end
      end
    end
    drive_mode = 1'b0;
  endtask

  task test_backpressure();
    @(negedge clock);
    if1.rsp_ready = 1'b0;
    if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_data = 8'h5A;
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
    repeat (5) @(negedge clock);
    for (int c = 6; c <= 10; c++) begin
      @(negedge clock);
      if (c == 7) begin if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_data = 8'h77; end
      checks++; if (if1.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid c%0d: got %b want 1", c, if1.rsp_valid); end
      checks++; if (if1.rsp_data !== 8'h5A) begin errors++; $display("FAIL bp_rsp_data c%0d: got %h want 5A", c, if1.rsp_data); end
      checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready c%0d: got %b want 0", c, if1.req_ready); end
      checks++; if (if1.bus_oe !== 1'b0) begin errors++; $display("FAIL bp_oe c%0d: got %b want 0", c, if1.bus_oe); end
    end
    if1.rsp_ready = 1'b1;
    @(negedge clock);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b want 1", if1.req_ready); end
    checks++; if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_rsp_valid: got %b want 0", if1.rsp_valid); end
    checks++; if (if1.bus_oe !== 1'b0) begin errors++; $display("FAIL bp_idle_oe: got %b want 0", if1.bus_oe); end
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
    @(negedge clock);
    checks++; if (if1.bus_oe !== 1'b1) begin errors++; $display("FAIL bp_pending_oe: got %b want 1", if1.bus_oe); end
    checks++; if (io_bus1 !== 8'h77) begin errors++; $display("FAIL bp_pending_bus: got %h want 77", io_bus1); end
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (if1.req_ready === 1'b1) break;
    end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_timeout: got req_ready %b want 1", if1.req_ready); end
  endtask

  task test_reset_mid();
    logic saw_rsp;
    @(negedge clock);
    if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_data = 8'hC3; if1.rsp_ready = 1'b1;
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (if1.io_strobe !== 1'b1) begin errors++; $display("FAIL mid_pre_strobe: got %b want 1", if1.io_strobe); end
    reset = 1'b1;
    #1;
    checks++; if (if1.bus_oe !== 1'b0) begin errors++; $display("FAIL mid_oe: got %b want 0", if1.bus_oe); end
    checks++; if (if1.io_strobe !== 1'b0) begin errors++; $display("FAIL mid_strobe: got %b want 0", if1.io_strobe); end
    checks++; if (io_bus1 !== 8'hFF) begin errors++; $display("FAIL mid_bus: got %h want FF", io_bus1); end
    checks++; if (if1.rsp_data !== 8'h00) begin errors++; $display("FAIL mid_rsp_data: got %h want 00", if1.rsp_data); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b want 1", if1.req_ready); end
    saw_rsp = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (if1.rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got rsp_valid seen %b want 0", saw_rsp); end
  endtask

  task test_back_to_back();
    int   wr_stb, oe0_run;
    logic seen_wr_rsp, rd_started, done;
    wr_stb = 0; oe0_run = 0;
    seen_wr_rsp = 1'b0; rd_started = 1'b0; done = 1'b0;
    @(negedge clock);
    if2.rsp_ready = 1'b1;
    if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_data = 8'h01;
    @(posedge clock); #1;
    if2.req_write = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (if2.io_strobe && !seen_wr_rsp) begin
        wr_stb++;
        checks++; if (io_bus2 !== 8'h01) begin errors++; $display("FAIL b2b_wr_bus: got %h want 01", io_bus2); end
      end
      if (if2.io_strobe && seen_wr_rsp) begin
        if (!rd_started) begin
          rd_started = 1'b1;
          if2.req_valid = 1'b0;
          checks++; if (oe0_run < 2) begin errors++; $display("FAIL b2b_turn_gap: got %0d oe-low cycles want >=2", oe0_run); end
        end
        checks++; if (if2.bus_oe !== 1'b0) begin errors++; $display("FAIL b2b_rd_oe: got %b want 0", if2.bus_oe); end
      end
      oe0_run = if2.bus_oe ? 0 : oe0_run + 1;
      if (if2.rsp_valid && !seen_wr_rsp) begin
        seen_wr_rsp = 1'b1;
        checks++; if (if2.rsp_write !== 1'b1) begin errors++; $display("FAIL b2b_wr_rsp_write: got %b want 1", if2.rsp_write); end
        checks++; if (if2.rsp_data !== 8'h01) begin errors++; $display("FAIL b2b_wr_rsp_data: got %h want 01", if2.rsp_data); end
      end else if (if2.rsp_valid && rd_started) begin
        done = 1'b1;
        checks++; if (if2.rsp_write !== 1'b0) begin errors++; $display("FAIL b2b_rd_rsp_write: got %b want 0", if2.rsp_write); end
        checks++; if (if2.rsp_data !== 8'hFF) begin errors++; $display("FAIL b2b_rd_rsp_data: got %h want FF", if2.rsp_data); end
        break;
      end
    end
    if2.req_valid = 1'b0;
    checks++; if (wr_stb != 3) begin errors++; $display("FAIL b2b_wr_strobe_len: got %0d want 3", wr_stb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got done %b want 1", done); end
  endtask

  initial begin
    checks = 0; errors = 0;
    drive_mode = 1'b0;
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_data = 8'h00; if1.rsp_ready = 1'b0;
    if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_data = 8'h00; if2.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read(1'b0, 8'hFF);
    test_read(1'b1, 8'h3C);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
